// File: rtl/i2s_tx.sv
// i2s_tx: I2S word-select master transmitter, sample pairs in via valid/ready, serial out on the falling bit clock.
// Optional build macro I2S_TX_REPEAT_ON_UNDERRUN_EN: an underrun resends the last loaded pair instead of zeros.
module i2s_tx #(
    parameter int WIDTH     = 16,
    parameter int SLOT_BITS = 16
) (
    input  logic             sclk_i,
    input  logic             rst_i,
    input  logic             sample_valid_i,
    input  logic [WIDTH-1:0] left_i,
    input  logic [WIDTH-1:0] right_i,
    output logic             sample_ready_o,
    output logic             ws_o,
    output logic             sdata_o,
    output logic             frame_load_o,
    output logic             underrun_o
);
    localparam int FB = 2 * SLOT_BITS;
    localparam int CW = $clog2(FB);
    localparam logic [CW-1:0] CNT_LAST  = CW'(FB - 1);
    localparam logic [CW-1:0] CNT_RIGHT = CW'(SLOT_BITS);

    logic [CW-1:0]      cnt_q, cnt_d;
    logic               ws_q, ws_d;
    logic               sdata_q, sdata_d;
    logic               full_q, full_d;
    logic               load_q, load_d;
    logic               under_q, under_d;
    logic [2*WIDTH-1:0] hold_q, hold_d;
    logic [FB-1:0]      shift_q, shift_d;
    logic [FB-1:0]      held_frame, idle_frame;
    logic               boundary, xfer;

    // each sample sits MSB-justified in its slot, bits below the LSB are zero
    assign held_frame = {SLOT_BITS'(hold_q[2*WIDTH-1:WIDTH]) << (SLOT_BITS - WIDTH),
                         SLOT_BITS'(hold_q[WIDTH-1:0]) << (SLOT_BITS - WIDTH)};

`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
    logic [FB-1:0] last_q, last_d;

    assign idle_frame = last_q;

    // remember the most recently loaded frame so an underrun can resend it
    always_comb last_d = load_d ? held_frame : last_q;

    // last-frame register, cleared so the first frame after reset is silent
    always_ff @(negedge sclk_i or negedge rst_i) begin
        if (!rst_i) last_q <= '0;
        else        last_q <= last_d;
    end
`else
    assign idle_frame = '0;
`endif

    // next state: free-running bit counter, frame load at wrap, MSB-first shift otherwise
    always_comb begin
        boundary = cnt_q == CNT_LAST;
        xfer     = sample_valid_i & ~full_q;
        cnt_d    = boundary ? '0 : cnt_q + 1'b1;
        ws_d     = cnt_d >= CNT_RIGHT;
        sdata_d  = shift_q[FB-1];
        shift_d  = boundary ? (full_q ? held_frame : idle_frame) : shift_q << 1;
        full_d   = xfer | (full_q & ~boundary);
        hold_d   = xfer ? {left_i, right_i} : hold_q;
        load_d   = boundary & full_q;
        under_d  = boundary & ~full_q;
    end

    // all state moves on the falling edge so the receiver samples stable data on the rising edge
    always_ff @(negedge sclk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q   <= CNT_LAST;
            ws_q    <= 1'b1;
            sdata_q <= 1'b0;
            full_q  <= 1'b0;
            load_q  <= 1'b0;
            under_q <= 1'b0;
            hold_q  <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            ws_q    <= ws_d;
            sdata_q <= sdata_d;
            full_q  <= full_d;
            load_q  <= load_d;
            under_q <= under_d;
            hold_q  <= hold_d;
            shift_q <= shift_d;
        end
    end

    assign sample_ready_o = ~full_q;
    assign ws_o           = ws_q;
    assign sdata_o        = sdata_q;
    assign frame_load_o   = load_q;
    assign underrun_o     = under_q;
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: two transmitters (16-bit and 32-bit slots) against a frame-level model and an I2S receiver decoder.
module tb_i2s_tx;
    localparam int SB0 = 16;
    localparam int SB1 = 32;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic        sclk  = 1'b0;
    logic        rst_n = 1'b1;
    logic        v   [2];
    logic [15:0] li  [2];
    logic [15:0] ri  [2];
    logic        rdy [2];
    logic        ws  [2];
    logic        sd  [2];
    logic        fl  [2];
    logic        ur  [2];
    int          ncmp  = 0;
    int          nfail = 0;

    bit [31:0] m_hold [2];
    bit [31:0] m_cf   [2];
    bit [31:0] m_pf   [2];
    bit [31:0] m_last [2];
    int        m_cnt  [2] = '{2*SB0-1, 2*SB1-1};
    bit        m_full [2];
    bit        m_load [2];
    bit        m_under[2];
    bit [31:0] expq0[$], expq1[$], rxlog0[$], rxlog1[$];

    bit [63:0] rw  [2];
    int        nb  [2];
    bit        wsp [2] = '{1'b1, 1'b1};
    bit [15:0] rl  [2];
    bit        lok [2];
    int        tick = 0, lastfall = 0, per1 = 0;

    always #5 sclk = ~sclk;

    i2s_tx #(.WIDTH(16), .SLOT_BITS(SB0)) u0 (
        .sclk_i(sclk), .rst_i(rst_n), .sample_valid_i(v[0]), .left_i(li[0]), .right_i(ri[0]),
        .sample_ready_o(rdy[0]), .ws_o(ws[0]), .sdata_o(sd[0]), .frame_load_o(fl[0]), .underrun_o(ur[0]));

    i2s_tx #(.WIDTH(16), .SLOT_BITS(SB1)) u1 (
        .sclk_i(sclk), .rst_i(rst_n), .sample_valid_i(v[1]), .left_i(li[1]), .right_i(ri[1]),
        .sample_ready_o(rdy[1]), .ws_o(ws[1]), .sdata_o(sd[1]), .frame_load_o(fl[1]), .underrun_o(ur[1]));

    function automatic int sbw(input int i);
        return i == 0 ? SB0 : SB1;
    endfunction

    // slot bit k of a {left,right} frame, counted MSB-first across both slots
    function automatic bit sbit(input bit [31:0] f, input int s, input int k);
        bit [15:0] x;
        int j;
        x = k < s ? f[31:16] : f[15:0];
        j = k < s ? k : k - s;
        return j < 16 ? x[15-j] : 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // frame-level reference: which pair each frame carries and what the handshake does
    always @(negedge sclk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            int fb;
            bit bnd, acc;
            fb = 2 * sbw(i);
            if (!rst_n) begin
                m_cnt[i] = fb - 1; m_full[i] = 0; m_hold[i] = 0; m_cf[i] = 0;
                m_pf[i] = 0; m_last[i] = 0; m_load[i] = 0; m_under[i] = 0;
            end else begin
                bnd = m_cnt[i] == fb - 1;
                acc = v[i] && !m_full[i];
                m_load[i]  = bnd && m_full[i];
                m_under[i] = bnd && !m_full[i];
                if (bnd) begin
                    m_pf[i] = m_cf[i];
                    m_cf[i] = m_full[i] ? m_hold[i] : (REP ? m_last[i] : 32'd0);
                    if (m_full[i]) m_last[i] = m_hold[i];
                    if (i == 0) expq0.push_back(m_cf[i]);
                    else        expq1.push_back(m_cf[i]);
                    m_full[i] = 0;
                end
                if (acc) begin
                    m_full[i] = 1;
                    m_hold[i] = {li[i], ri[i]};
                end
                m_cnt[i] = (m_cnt[i] + 1) % fb;
            end
        end
        if (!rst_n) begin
            expq0.delete();
            expq1.delete();
        end
    end

    // rising-edge per-bit checks and an I2S receiver decoding each completed frame
    always @(posedge sclk) begin
        for (int i = 0; i < 2; i++) begin
            int s;
            bit e;
            bit [15:0] w;
            bit [31:0] p;
            s = sbw(i);
            e = m_cnt[i] == 0 ? sbit(m_pf[i], s, 2*s-1) : sbit(m_cf[i], s, m_cnt[i] - 1);
            chk($sformatf("ready%0d", i), 32'(rdy[i]), 32'(!m_full[i]));
            chk($sformatf("ws%0d", i), 32'(ws[i]), 32'(m_cnt[i] >= s));
            chk($sformatf("sdata%0d", i), 32'(sd[i]), 32'(e));
            chk($sformatf("load%0d", i), 32'(fl[i]), 32'(m_load[i]));
            chk($sformatf("under%0d", i), 32'(ur[i]), 32'(m_under[i]));
            if (!rst_n) begin
                nb[i] = 0; lok[i] = 0; wsp[i] = 1'b1;
            end else begin
                rw[i] = {rw[i][62:0], sd[i] === 1'b1};
                nb[i]++;
                if (i == 1 && wsp[1] && ws[1] === 1'b0) begin
                    per1 = tick - lastfall;
                    lastfall = tick;
                end
                if (ws[i] !== wsp[i]) begin
                    if (nb[i] == s) begin
                        w = 16'(rw[i] >> (s - 16));
                        if (s > 16) chk($sformatf("pad%0d", i), 32'(rw[i] & ((64'd1 << (s - 16)) - 64'd1)), 32'd0);
                        if (!wsp[i]) begin
                            rl[i] = w;
                            lok[i] = 1;
                        end else if (lok[i]) begin
                            p = {rl[i], w};
                            lok[i] = 0;
                            if (i == 0) begin
                                rxlog0.push_back(p);
                                chk("rx0_pending", 32'(expq0.size() != 0), 32'd1);
                                if (expq0.size() != 0) chk("rx0_data", p, expq0.pop_front());
                            end else begin
                                rxlog1.push_back(p);
                                chk("rx1_pending", 32'(expq1.size() != 0), 32'd1);
                                if (expq1.size() != 0) chk("rx1_data", p, expq1.pop_front());
                            end
                        end
                    end
                    nb[i] = 0;
                end
                wsp[i] = ws[i] === 1'b1;
            end
        end
        tick++;
    end

    task automatic send(input int i, input logic [15:0] l, input logic [15:0] r);
        int t = 0;
        v[i] = 1'b1; li[i] = l; ri[i] = r;
        while (rdy[i] !== 1'b1 && t < 200) begin
            @(posedge sclk);
            t++;
        end
        if (t >= 200) begin
            ncmp++; nfail++;
            $error("FAIL send%0d observed=busy expected=ready", i);
        end
        @(posedge sclk);
        v[i] = 1'b0;
    endtask

    task automatic wait_cnt(input int c);
        int t = 0;
        do begin
            @(posedge sclk);
            t++;
        end while (m_cnt[0] != c && t < 200);
        if (t >= 200) begin
            ncmp++; nfail++;
            $error("FAIL wait_cnt observed=timeout expected=cnt%0d", c);
        end
    endtask

    initial begin
        int nu, nl, xf;
        bit [31:0] prev;
        v = '{1'b0, 1'b0}; li = '{16'h0, 16'h0}; ri = '{16'h0, 16'h0};
        #1 rst_n = 1'b0;
        repeat (3) @(posedge sclk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_ws", 32'(ws[i]), 32'd1);
            chk("rst_sdata", 32'(sd[i]), 32'd0);
            chk("rst_ready", 32'(rdy[i]), 32'd1);
            chk("rst_load", 32'(fl[i]), 32'd0);
            chk("rst_under", 32'(ur[i]), 32'd0);
        end
        @(posedge sclk);
        rst_n = 1'b1;
        fork
            send(0, 16'hA5F0, 16'h0F3C);
            send(1, 16'hFFFF, 16'h0001);
        join
        chk("first_under", 32'(ur[0]), 32'd1);
        chk("first_load", 32'(fl[0]), 32'd0);
        wait_cnt(0);
        chk("load_frame2", 32'(fl[0]), 32'd1);
        chk("load_frame2_ur", 32'(ur[0]), 32'd0);
        wait_cnt(0);
        repeat (2) @(posedge sclk);
        chk("rx_first", rxlog0[0], 32'h0);
        chk("rx_a5f0", rxlog0[1], 32'hA5F00F3C);

        send(0, 16'h1234, 16'h5678);
        wait_cnt(0);
        nu = 0; nl = 0;
        repeat (96) begin
            @(posedge sclk);
            nu += int'(ur[0]);
            nl += int'(fl[0]);
        end
        chk("ur_count", 32'(nu), 32'd3);
        chk("fl_count", 32'(nl), 32'd0);
        repeat (2) @(posedge sclk);
        chk("rx_1234", rxlog0[$-2], 32'h12345678);
        chk("rx_underrun", rxlog0[$], REP ? 32'h12345678 : 32'h0);

        wait_cnt(5);
        v[0] = 1'b1; li[0] = 16'($urandom); ri[0] = 16'($urandom);
        xf = 0;
        repeat (128) begin
            if (rdy[0] === 1'b1) xf++;
            @(posedge sclk);
            li[0] = 16'($urandom); ri[0] = 16'($urandom);
        end
        v[0] = 1'b0;
        chk("bp_xfers", 32'(xf), 32'd5);

        wait_cnt(0);
        wait_cnt(31);
        prev = REP ? m_last[0] : 32'h0;
        v[0] = 1'b1; li[0] = 16'h7FFF; ri[0] = 16'h8000;
        @(posedge sclk);
        v[0] = 1'b0;
        chk("same_under", 32'(ur[0]), 32'd1);
        chk("same_load", 32'(fl[0]), 32'd0);
        chk("same_ready", 32'(rdy[0]), 32'd0);
        wait_cnt(0);
        chk("next_load", 32'(fl[0]), 32'd1);
        chk("next_ready", 32'(rdy[0]), 32'd1);
        wait_cnt(0);
        repeat (2) @(posedge sclk);
        chk("rx_7fff", rxlog0[$], 32'h7FFF8000);
        chk("rx_before_7fff", rxlog0[$-1], prev);

        chk("rx1_first", rxlog1[0], 32'h0);
        chk("rx1_ffff", rxlog1[1], 32'hFFFF0001);
        chk("ws1_period", 32'(per1), 32'd64);

        wait_cnt(3);
        send(0, 16'h2222, 16'h3333);
        chk("held_ready", 32'(rdy[0]), 32'd0);
        wait_cnt(9);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ws", 32'(ws[0]), 32'd1);
        chk("mid_rst_sdata", 32'(sd[0]), 32'd0);
        chk("mid_rst_ready", 32'(rdy[0]), 32'd1);
        chk("mid_rst_load", 32'(fl[0]), 32'd0);
        chk("mid_rst_under", 32'(ur[0]), 32'd0);
        repeat (2) @(posedge sclk);
        rst_n = 1'b1;
        @(posedge sclk);
        chk("post_rst_under", 32'(ur[0]), 32'd1);
        chk("post_rst_load", 32'(fl[0]), 32'd0);
        send(0, 16'h4444, 16'h5555);
        wait_cnt(0);
        wait_cnt(0);
        repeat (2) @(posedge sclk);
        chk("rx_after_rst", rxlog0[$], 32'h44445555);
        chk("rx_rst_underrun", rxlog0[$-1], 32'h0);

        repeat (64) @(posedge sclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
